pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. Drives the PC write enable (`pc_en`) of the fetch unit and the enable/flush controls of the IF/ID, ID/EXE and EXE/MEM pipeline registers. Its decisions come from jump/branch resolution, load-use detection and a data-memory busy handshake. It also owns the post-reset boot sequence that lets the synchronous instruction RAM deliver its first word before the pipeline advances.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and global widths.
// The perf counters in pipe_hazard_ctrl are built only when HAZARD_PERF_CNT_EN is defined.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif
`ifndef ADDRWIDTH
`define ADDRWIDTH 32
`endif

package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_LU_STALL = 2'd2,
        ST_MEM_WAIT = 2'd3
    } hz_state_t;

    localparam int CNT_W     = `DATAWIDTH;
    localparam int BOOT_CNTW = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: a load in EXE whose destination feeds a source read in ID.
module load_use_detect #(
    parameter int REGW = 5
) (
    input  logic            exe_mem_read,
    input  logic [REGW-1:0] exe_rd,
    input  logic [REGW-1:0] idu_rs1,
    input  logic [REGW-1:0] idu_rs2,
    input  logic            idu_rs1_used,
    input  logic            idu_rs2_used,
    output logic            lu_hazard
);

    logic rd_nonzero;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load into it never produces a dependency.
    assign rd_nonzero = |exe_rd;
    assign rs1_hit    = idu_rs1_used && (idu_rs1 == exe_rd);
    assign rs2_hit    = idu_rs2_used && (idu_rs2 == exe_rd);
    assign lu_hazard  = exe_mem_read && rd_nonzero && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: boot hold, redirects, load-use and memory freeze.
// Optional macro HAZARD_PERF_CNT_EN builds the saturating stall/flush performance counters.
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int REGW        = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IDU_JAL_instr,
    input  logic             EXE_JALR_instr,
    input  logic             B_type_jump_flag,
    input  logic             EXE_mem_read,
    input  logic [REGW-1:0]  EXE_rd,
    input  logic [REGW-1:0]  IDU_rs1,
    input  logic [REGW-1:0]  IDU_rs2,
    input  logic             IDU_rs1_used,
    input  logic             IDU_rs2_used,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             IF_ID_en,
    output logic             ID_EXE_en,
    output logic             EXE_MEM_en,
    output logic             IF_ID_flush,
    output logic             ID_EXE_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [BOOT_CNTW-1:0] BOOT_INIT = BOOT_CNTW'(BOOT_CYCLES - 1);

    hz_state_t            state;
    hz_state_t            state_nxt;
    logic [BOOT_CNTW-1:0] boot_cnt;
    logic [BOOT_CNTW-1:0] boot_cnt_nxt;
    logic                 lu_hazard;
    logic                 exe_redirect;

    load_use_detect #(.REGW(REGW)) u_lu_detect (
        .exe_mem_read (EXE_mem_read),
        .exe_rd       (EXE_rd),
        .idu_rs1      (IDU_rs1),
        .idu_rs2      (IDU_rs2),
        .idu_rs1_used (IDU_rs1_used),
        .idu_rs2_used (IDU_rs2_used),
        .lu_hazard    (lu_hazard)
    );

    assign exe_redirect = EXE_JALR_instr | B_type_jump_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            boot_cnt <= BOOT_INIT;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state    <= state_nxt;
            boot_cnt <= boot_cnt_nxt;
        end
    end

    // Every state except BOOT drives the same priority evaluation; states only steer the next step.
    always_comb begin
        // NOTE: every output gets a default up front so no path through the case can infer a latch.
        pc_en        = 1'b1;
        IF_ID_en     = 1'b1;
        ID_EXE_en    = 1'b1;
        EXE_MEM_en   = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EXE_flush = 1'b0;
        state_nxt    = ST_RUN;
        boot_cnt_nxt = boot_cnt;

        if (state == ST_BOOT) begin
            pc_en        = 1'b0;
            IF_ID_en     = 1'b0;
            ID_EXE_en    = 1'b0;
            EXE_MEM_en   = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EXE_flush = 1'b1;
            if (boot_cnt == '0) begin
                state_nxt = ST_RUN;
            end else begin
                state_nxt    = ST_BOOT;
                boot_cnt_nxt = boot_cnt - 1'b1;
            end
        end else if (mem_busy) begin
            pc_en      = 1'b0;
            IF_ID_en   = 1'b0;
            ID_EXE_en  = 1'b0;
            EXE_MEM_en = 1'b0;
            state_nxt  = ST_MEM_WAIT;
        end else if (exe_redirect) begin
            IF_ID_flush  = 1'b1;
            ID_EXE_flush = 1'b1;
        end else if (lu_hazard) begin
            pc_en        = 1'b0;
            IF_ID_en     = 1'b0;
            ID_EXE_flush = 1'b1;
            // The load reaches MEM on this edge, so only a RUN-state detection needs the stall marker.
            state_nxt    = (state == ST_RUN) ? ST_LU_STALL : ST_RUN;
        end else if (IDU_JAL_instr) begin
            IF_ID_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (state != ST_BOOT) begin
            if (!pc_en && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (IF_ID_flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: boot, load-use, redirects, memory freeze, async reset, counters.
module tb_pipe_hazard_ctrl;

    localparam int REGW = 5;

    // Control vector order: {pc_en, IF_ID_en, ID_EXE_en, EXE_MEM_en, IF_ID_flush, ID_EXE_flush}
    localparam logic [5:0] CTL_BOOT   = 6'b0000_11;
    localparam logic [5:0] CTL_RUN    = 6'b1111_00;
    localparam logic [5:0] CTL_FREEZE = 6'b0000_00;
    localparam logic [5:0] CTL_LU     = 6'b0011_01;
    localparam logic [5:0] CTL_EXE    = 6'b1111_11;
    localparam logic [5:0] CTL_JAL    = 6'b1111_10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            IDU_JAL_instr, EXE_JALR_instr, B_type_jump_flag, EXE_mem_read;
    logic [REGW-1:0] EXE_rd, IDU_rs1, IDU_rs2;
    logic            IDU_rs1_used, IDU_rs2_used, mem_busy;
    logic            pc_en, IF_ID_en, ID_EXE_en, EXE_MEM_en, IF_ID_flush, ID_EXE_flush;
    logic [31:0]     stall_cnt, flush_cnt;
    logic [5:0]      ctl;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.BOOT_CYCLES(2), .REGW(REGW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .IDU_JAL_instr    (IDU_JAL_instr),
        .EXE_JALR_instr   (EXE_JALR_instr),
        .B_type_jump_flag (B_type_jump_flag),
        .EXE_mem_read     (EXE_mem_read),
        .EXE_rd           (EXE_rd),
        .IDU_rs1          (IDU_rs1),
        .IDU_rs2          (IDU_rs2),
        .IDU_rs1_used     (IDU_rs1_used),
        .IDU_rs2_used     (IDU_rs2_used),
        .mem_busy         (mem_busy),
        .pc_en            (pc_en),
        .IF_ID_en         (IF_ID_en),
        .ID_EXE_en        (ID_EXE_en),
        .EXE_MEM_en       (EXE_MEM_en),
        .IF_ID_flush      (IF_ID_flush),
        .ID_EXE_flush     (ID_EXE_flush),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    assign ctl = {pc_en, IF_ID_en, ID_EXE_en, EXE_MEM_en, IF_ID_flush, ID_EXE_flush};

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        IDU_JAL_instr    = 1'b0;
        EXE_JALR_instr   = 1'b0;
        B_type_jump_flag = 1'b0;
        EXE_mem_read     = 1'b0;
        EXE_rd           = '0;
        IDU_rs1          = '0;
        IDU_rs2          = '0;
        IDU_rs1_used     = 1'b0;
        IDU_rs2_used     = 1'b0;
        mem_busy         = 1'b0;
    endtask

    task automatic set_lu(input logic [REGW-1:0] rd, input logic [REGW-1:0] rs1, input logic u1,
                          input logic [REGW-1:0] rs2, input logic u2);
        EXE_mem_read = 1'b1;
        EXE_rd       = rd;
        IDU_rs1      = rs1;
        IDU_rs1_used = u1;
        IDU_rs2      = rs2;
        IDU_rs2_used = u2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #3;
        total++;
        if (ctl !== CTL_BOOT) $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_BOOT);
        else passed++;
        total++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        else passed++;
        tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (ctl !== CTL_BOOT) $display("FAIL boot_cycle1: got %b expected %b", ctl, CTL_BOOT);
        else passed++;
        tick();
        total++;
        if (ctl !== CTL_BOOT) $display("FAIL boot_cycle2: got %b expected %b", ctl, CTL_BOOT);
        else passed++;
        tick();
        total++;
        if (ctl !== CTL_RUN) $display("FAIL boot_release: got %b expected %b", ctl, CTL_RUN);
        else passed++;
    endtask

    task automatic test_load_use();
        tick();
        set_lu(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        #1;
        total++;
        if (ctl !== CTL_LU) $display("FAIL lu_rs2: got %b expected %b", ctl, CTL_LU);
        else passed++;
        tick();
        clear_inputs();
        #1;
        total++;
        if (ctl !== CTL_RUN) $display("FAIL lu_one_cycle: got %b expected %b", ctl, CTL_RUN);
        else passed++;
        tick();
        set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        total++;
        if (ctl !== CTL_RUN) $display("FAIL lu_rd_zero: got %b expected %b", ctl, CTL_RUN);
        else passed++;
        tick();
        set_lu(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
        #1;
        total++;
        if (ctl !== CTL_RUN) $display("FAIL lu_rs1_unused: got %b expected %b", ctl, CTL_RUN);
        else passed++;
        tick();
        set_lu(5'd31, 5'd31, 1'b1, 5'd2, 1'b0);
        #1;
        total++;
        if (ctl !== CTL_LU) $display("FAIL lu_rs1: got %b expected %b", ctl, CTL_LU);
        else passed++;
        tick();
        clear_inputs();
    endtask

    task automatic test_branch();
        tick();
        set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        B_type_jump_flag = 1'b1;
        #1;
        total++;
        if (ctl !== CTL_EXE) $display("FAIL branch_over_lu: got %b expected %b", ctl, CTL_EXE);
        else passed++;
        tick();
        clear_inputs();
        IDU_JAL_instr = 1'b1;
        #1;
        total++;
        if (ctl !== CTL_JAL) $display("FAIL jal_only: got %b expected %b", ctl, CTL_JAL);
        else passed++;
        tick();
        clear_inputs();
        EXE_JALR_instr = 1'b1;
        IDU_JAL_instr  = 1'b1;
        #1;
        total++;
        if (ctl !== CTL_EXE) $display("FAIL jalr_with_jal: got %b expected %b", ctl, CTL_EXE);
        else passed++;
        tick();
        clear_inputs();
        #1;
        total++;
        if (ctl !== CTL_RUN) $display("FAIL after_redirect: got %b expected %b", ctl, CTL_RUN);
        else passed++;
    endtask

    task automatic test_mem_freeze();
        tick();
        mem_busy         = 1'b1;
        B_type_jump_flag = 1'b1;
        set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ctl !== CTL_FREEZE) $display("FAIL freeze_cycle%0d: got %b expected %b", i, ctl, CTL_FREEZE);
            else passed++;
            tick();
        end
        mem_busy = 1'b0;
        #1;
        total++;
        if (ctl !== CTL_EXE) $display("FAIL freeze_release_branch: got %b expected %b", ctl, CTL_EXE);
        else passed++;
        tick();
        clear_inputs();
        #1;
        total++;
        if (ctl !== CTL_RUN) $display("FAIL freeze_after: got %b expected %b", ctl, CTL_RUN);
        else passed++;
    endtask

    task automatic test_reset_mid();
        tick();
        mem_busy = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ctl !== CTL_BOOT) $display("FAIL reset_mid_async: got %b expected %b", ctl, CTL_BOOT);
        else passed++;
        tick();
        clear_inputs();
        rst_n         = 1'b1;
        IDU_JAL_instr = 1'b1;
        mem_busy      = 1'b1;
        #1;
        total++;
        if (ctl !== CTL_BOOT) $display("FAIL reboot_cycle1: got %b expected %b", ctl, CTL_BOOT);
        else passed++;
        tick();
        total++;
        if (ctl !== CTL_BOOT) $display("FAIL reboot_cycle2: got %b expected %b", ctl, CTL_BOOT);
        else passed++;
        tick();
        clear_inputs();
        #1;
        total++;
        if (ctl !== CTL_RUN) $display("FAIL reboot_release: got %b expected %b", ctl, CTL_RUN);
        else passed++;
    endtask

    task automatic test_perf();
        logic [31:0] exp_stall;
        logic [31:0] exp_flush;
`ifdef HAZARD_PERF_CNT_EN
        exp_stall = 32'd1;
        exp_flush = 32'd2;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        total++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
            $display("FAIL perf_after_boot: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        else passed++;
        tick();
        set_lu(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
        tick();
        clear_inputs();
        tick();
        IDU_JAL_instr = 1'b1;
        tick();
        clear_inputs();
        B_type_jump_flag = 1'b1;
        tick();
        clear_inputs();
        tick();
        total++;
        if (stall_cnt !== exp_stall) $display("FAIL perf_stall: got %0d expected %0d", stall_cnt, exp_stall);
        else passed++;
        total++;
        if (flush_cnt !== exp_flush) $display("FAIL perf_flush: got %0d expected %0d", flush_cnt, exp_flush);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_freeze();
        test_reset_mid();
        test_perf();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
